neuron_mac: RTL
===============

// Module: neuron_mac
// PURPOSE
//  Single-neuron dot-product engine sitting directly downstream of two memory instances (input vector, weights).
//  On start it walks both memories, multiply-accumulates signed operands, adds bias, applies ReLU and saturates.
//  Result goes out on a valid/ready handshake. Layer control issues one start per neuron, selecting the weight row via w_base.
// PARAMETERS
//  WIDTH      8                          operand/result width, signed two's complement
//  N_IN       16                         inputs per neuron (>=1)
//  W_SIZE     256                        depth of weight memory; W_AW = $clog2(W_SIZE)
//  FRAC_BITS  4                          fixed-point fraction bits; product scaled back by >>> FRAC_BITS
//  ACC_W      2*WIDTH+$clog2(N_IN)+1     accumulator width (localparam, not overridable)
// PORTS
//  clk        in   1                   rising-edge clock
//  rst        in   1                   async active-high reset
//  start      in   1                   begin one neuron; sampled only in IDLE
//  w_base     in   W_AW                weight row base address, latched on accepted start
//  bias       in   WIDTH               signed bias, latched on accepted start
//  in_addr    out  $clog2(N_IN)        address to input-vector memory
//  in_data    in   WIDTH               combinational read data from input memory
//  w_addr     out  W_AW                address to weight memory
//  w_data     in   WIDTH               combinational read data from weight memory
//  busy       out  1                   high in every state except IDLE
//  out_data   out  WIDTH               ReLU'd, saturated neuron output
//  out_valid  out  1                   out_data valid; held until out_ready
//  out_ready  in   1                   consumer accepts out_data
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, idx=0, in_addr=0, w_addr=0, out_data=0, out_valid=0, busy=0.
//  FSM IDLE -> MAC -> POST -> OUT -> IDLE.
//   IDLE: start=1 latches w_base/bias, clears acc and idx -> MAC.
//   MAC: in_addr=idx, w_addr=w_base+idx (wraps mod W_SIZE).
//        acc += sext(in_data*w_data) each cycle; after idx==N_IN-1 -> POST. Lasts exactly N_IN cycles.
//   POST: s = (acc >>> FRAC_BITS) + sext(bias).
//         out_data = s<0 ? 0 : (s>2^(WIDTH-1)-1 ? 2^(WIDTH-1)-1 : s); out_valid<=1 -> OUT.
//   OUT: hold out_data/out_valid stable until out_ready=1. On that edge out_valid<=0 -> IDLE.
//  Latency: start edge to out_valid high = N_IN+1 cycles. Back-to-back start accepted the cycle after handshake.
//  start while busy: ignored, no effect on running computation.
//  Memory addresses are held at last value outside MAC; block never writes memory.
//  Arithmetic: products signed WIDTH x WIDTH -> 2*WIDTH; acc never overflows by ACC_W sizing.
//  Shift is arithmetic; bias is added after the shift.
//  rst asserted mid-operation: immediate return to reset values; partial result discarded, no out_valid pulse.
// STRUCTURE
//  Package nn_pkg: typedef enum logic [1:0] {IDLE,MAC,POST,OUT} mac_state_t; function sat_relu(acc, bias) -> WIDTH.
//  No sub-module: single FSM + datapath. Both memories instantiated by parent layer, not here.
// TESTING
//  1 Reset: assert rst mid-MAC -> all outputs 0 next edge, state IDLE, no out_valid later.
//  2 Unit dot: FRAC_BITS=0, all inputs=1, weights=1, bias=0, N_IN=16 -> out_data=16 at cycle 17.
//  3 ReLU: inputs=1, weights=-2, bias=5, FRAC_BITS=0 -> s=-27 -> out_data=0.
//  4 Saturation: inputs=127, weights=127, bias=0, FRAC_BITS=4 -> out_data=127.
//  5 Handshake: out_ready low 5 cycles -> out_valid/out_data stable. start pulsed meanwhile ignored.
//     Ready high -> IDLE, next start accepted.
//  6 Row select/wrap: w_base=W_SIZE-4 -> w_addr sequence 252..255,0..11; compare to golden model.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// Shared types and the output activation for the neuron MAC engine.
package nn_pkg;

    typedef enum logic [1:0] {IDLE, MAC, POST, OUT} mac_state_t;

    // Shift, add bias, then clamp to [0, 2^(width-1)-1]; caller keeps the low width bits.
    function automatic logic signed [63:0] sat_relu(
        input logic signed [63:0] acc,
        input logic signed [63:0] bias,
        input int unsigned        frac_bits,
        input int unsigned        width
    );
        logic signed [63:0] s;
        logic signed [63:0] max_pos;
        s       = (acc >>> frac_bits) + bias;
        max_pos = (64'sd1 <<< (width - 1)) - 64'sd1;
        if (s < 0)
            return '0;
        else if (s > max_pos)
            return max_pos;
        return s;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Control, memory-read and result handshake signals of one neuron MAC engine.
interface neuron_mac_if #(
    parameter int WIDTH  = 8,
    parameter int N_IN   = 16,
    parameter int W_SIZE = 256
);
    localparam int W_AW  = $clog2(W_SIZE);
    localparam int IN_AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic              start;
    logic [W_AW-1:0]   w_base;
    logic [WIDTH-1:0]  bias;
    logic [IN_AW-1:0]  in_addr;
    logic [WIDTH-1:0]  in_data;
    logic [W_AW-1:0]   w_addr;
    logic [WIDTH-1:0]  w_data;
    logic              busy;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output start, w_base, bias, in_data, w_data, out_ready,
        input  in_addr, w_addr, busy, out_data, out_valid
    );

    modport slave (
        input  start, w_base, bias, in_data, w_data, out_ready,
        output in_addr, w_addr, busy, out_data, out_valid
    );

endinterface

// File: rtl/neuron_mac.sv
// Single-neuron dot product: walks input and weight memories, accumulates,
// adds bias, applies ReLU with saturation and presents the result on valid/ready.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_IN      = 16,
    parameter int W_SIZE    = 256,
    parameter int FRAC_BITS = 4
) (
    input logic        clk,
    input logic        rst,
    neuron_mac_if.slave bus
);
    localparam int W_AW  = $clog2(W_SIZE);
    localparam int IN_AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int ACC_W = 2 * WIDTH + $clog2(N_IN) + 1;

    localparam logic [IN_AW-1:0] IDX_LAST = IN_AW'(N_IN - 1);
    localparam logic [W_AW-1:0]  W_LAST   = W_AW'(W_SIZE - 1);

    mac_state_t               state;
    logic signed [ACC_W-1:0]  acc;
    logic [IN_AW-1:0]         idx;
    logic [W_AW-1:0]          w_addr_q;
    logic [WIDTH-1:0]         bias_q;
    logic [WIDTH-1:0]         out_data_q;
    logic                     out_valid_q;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [63:0]        post_s;
    logic                      unused_post;

    assign prod     = $signed(bus.in_data) * $signed(bus.w_data);
    assign prod_ext = {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
    assign post_s   = sat_relu({{(64 - ACC_W){acc[ACC_W-1]}}, acc},
                               {{(64 - WIDTH){bias_q[WIDTH-1]}}, bias_q},
                               FRAC_BITS, WIDTH);
    // Clamped value always fits in WIDTH bits; upper bits are sign fill only.
    assign unused_post = ^post_s[63:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            idx         <= '0;
            w_addr_q    <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bias_q   <= bus.bias;
                        w_addr_q <= bus.w_base;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    // Addresses stop on the last element so they hold outside MAC.
                    if (idx == IDX_LAST) begin
                        state <= POST;
                    end else begin
                        idx      <= idx + 1'b1;
                        w_addr_q <= (w_addr_q == W_LAST) ? '0 : w_addr_q + 1'b1;
                    end
                end
                POST: begin
                    out_data_q  <= post_s[WIDTH-1:0];
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_addr   = idx;
    assign bus.w_addr    = w_addr_q;
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule
